// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// -----------------------------------------------------------------------------
// Bit-serial adder controller. A single full-adder cell is stepped over WIDTH
// clock cycles to form {cout_o, sum_o} = a_i + b_i + cin_i. The operands and
// carry-in are latched when START is accepted, so they may change freely while
// the addition runs.
//
// Ports
//   clk_i    system clock, rising edge
//   rst_i    asynchronous active-high reset
//   start_i  begin an addition (level-sampled in IDLE and FIN, ignored in ADD)
//   a_i      operand A, captured on an accepted start
//   b_i      operand B, captured on an accepted start
//   cin_i    carry-in, captured on an accepted start
//   busy_o   high while the addition is in progress
//   done_o   one-cycle pulse in the cycle after the result registers update
//   sum_o    registered sum, held until the next completion
//   cout_o   registered carry-out, held until the next completion
// -----------------------------------------------------------------------------
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    // Only WIDTH-1 partial sum bits need storing: the final bit goes straight
    // from the adder cell into the result register on the last ADD edge.
    logic [WIDTH-2:0] s_sh_q, s_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;

    // The single full-adder cell.
    logic             fa_s;
    logic             fa_c;
    logic [WIDTH-1:0] sum_full;

    assign fa_s     = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
    assign fa_c     = (a_sh_q[0] & b_sh_q[0]) | (carry_q & (a_sh_q[0] ^ b_sh_q[0]));
    assign sum_full = {fa_s, s_sh_q};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            carry_q <= 1'b0;
            s_sh_q  <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            carry_q <= carry_d;
            s_sh_q  <= s_sh_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        carry_d = carry_q;
        s_sh_d  = s_sh_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;

        case (state_q)
            ST_IDLE, ST_FIN: begin
                if (start_i) begin
                    a_sh_d  = a_i;
                    b_sh_d  = b_i;
                    carry_d = cin_i;
                    cnt_d   = '0;
                    state_d = ST_ADD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ADD: begin
                carry_d = fa_c;
                a_sh_d  = a_sh_q >> 1;
                b_sh_d  = b_sh_q >> 1;
                s_sh_d  = sum_full[WIDTH-1:1];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    sum_d   = sum_full;
                    cout_d  = fa_c;
                    state_d = ST_FIN;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy_o = (state_q == ST_ADD);
    assign done_o = (state_q == ST_FIN);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: directed scenarios on a WIDTH=8 instance
// and a continuous-start random run on a WIDTH=4 instance.
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic       start = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0;
    logic [3:0] b4 = '0;
    logic       cin4 = 1'b0;
    logic       busy4;
    logic       done4;
    logic [3:0] sum4;
    logic       cout4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .a_i(a), .b_i(b), .cin_i(cin),
        .busy_o(busy), .done_o(done), .sum_o(sum), .cout_o(cout)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .start_i(start4), .a_i(a4), .b_i(b4), .cin_i(cin4),
        .busy_o(busy4), .done_o(done4), .sum_o(sum4), .cout_o(cout4)
    );

    // Advance one rising edge and settle; inputs are driven and outputs
    // sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_hold: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy, done, sum, cout);
        end
        rst = 1'b0;
        tick();
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy, done, sum, cout);
        end
        $display("reset: busy=%0b done=%0b sum=%h cout=%0b", busy, done, sum, cout);
    endtask

    // Single job with full timing check: 8 busy cycles, then one DONE cycle,
    // then the result stays held in IDLE.
    task automatic test_basic(input logic [7:0] ta, input logic [7:0] tb_, input logic tc,
                              input logic [7:0] es, input logic ec);
        a = ta; b = tb_; cin = tc; start = 1'b1;
        tick();
        start = 1'b0;
        a = ~ta; b = ~tb_; cin = ~tc;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL basic_busy[%0d]: busy=%0b done=%0b, required busy=1 done=0", i, busy, done);
            end
            tick();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b1 || sum !== es || cout !== ec) begin
            errors++;
            $display("FAIL basic_done: busy=%0b done=%0b sum=%h cout=%0b, required 0 1 %h %0b",
                     busy, done, sum, cout, es, ec);
        end
        tick();
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || sum !== es || cout !== ec) begin
            errors++;
            $display("FAIL basic_hold: busy=%0b done=%0b sum=%h cout=%0b, required 0 0 %h %0b",
                     busy, done, sum, cout, es, ec);
        end
        $display("basic: %h+%h+%0b -> sum=%h cout=%0b", ta, tb_, tc, sum, cout);
    endtask

    task automatic test_carry_chain();
        logic [7:0] va [3] = '{8'hFF, 8'hFF, 8'h00};
        logic [7:0] vb [3] = '{8'h01, 8'hFF, 8'h00};
        logic       vc [3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] vs [3] = '{8'h00, 8'hFF, 8'h01};
        logic       vo [3] = '{1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 3; k++) begin
            a = va[k]; b = vb[k]; cin = vc[k]; start = 1'b1;
            tick();
            start = 1'b0;
            for (int i = 0; i < 8; i++) tick();
            checks++;
            if (done !== 1'b1 || sum !== vs[k] || cout !== vo[k]) begin
                errors++;
                $display("FAIL carry_chain[%0d]: done=%0b sum=%h cout=%0b, required 1 %h %0b",
                         k, done, sum, cout, vs[k], vo[k]);
            end
            $display("carry: %h+%h+%0b -> sum=%h cout=%0b", va[k], vb[k], vc[k], sum, cout);
            tick();
        end
    endtask

    // START pulses and operand changes during ADD must not disturb the job.
    task automatic test_start_ignored();
        int done_cnt = 0;
        int done_at  = -1;
        a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            if (i == 3) begin start = 1'b1; a = 8'h00; b = 8'h00; end
            if (i == 4) start = 1'b0;
            if (i == 6) start = 1'b1;
            if (i == 7) start = 1'b0;
            tick();
            if (done === 1'b1) begin
                done_cnt++;
                done_at = i;
                checks++;
                if (sum !== 8'h46 || cout !== 1'b0) begin
                    errors++;
                    $display("FAIL ignored_sum: sum=%h cout=%0b, required 46 0", sum, cout);
                end
            end
        end
        checks++;
        if (done_cnt != 1 || done_at != 8) begin
            errors++;
            $display("FAIL ignored_done: count=%0d at=%0d, required count=1 at=8", done_cnt, done_at);
        end
        $display("ignored: 12+34 -> sum=%h dones=%0d", sum, done_cnt);
    endtask

    task automatic test_reset_abort();
        int done_cnt = 0;
        a = 8'hAA; b = 8'h11; cin = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        checks++;
        if (busy !== 1'b1 || sum !== 8'h46) begin
            errors++;
            $display("FAIL abort_pre: busy=%0b sum=%h, required 1 46", busy, sum);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, sum, cout} !== 11'd0) begin
            errors++;
            $display("FAIL abort_async: busy=%0b done=%0b sum=%h cout=%0b, required all 0", busy, done, sum, cout);
        end
        tick();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (done === 1'b1 || busy === 1'b1) done_cnt++;
        end
        checks++;
        if (done_cnt != 0) begin
            errors++;
            $display("FAIL abort_nodone: activity cycles=%0d, required 0", done_cnt);
        end
        $display("abort: reset mid-ADD, activity after=%0d", done_cnt);
        test_basic(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] va [4] = '{8'h01, 8'h03, 8'h80, 8'h00};
        logic [7:0] vb [4] = '{8'h02, 8'h04, 8'h80, 8'h00};
        logic [7:0] vs [3] = '{8'h03, 8'h07, 8'h00};
        logic       vo [3] = '{1'b0, 1'b0, 1'b1};
        a = va[0]; b = vb[0]; cin = 1'b0; start = 1'b1;
        tick();
        for (int j = 0; j < 3; j++) begin
            a = va[j+1]; b = vb[j+1];
            if (j == 2) start = 1'b0;
            for (int i = 0; i < 8; i++) begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy[%0d.%0d]: busy=%0b done=%0b, required 1 0", j, i, busy, done);
                end
                tick();
            end
            checks++;
            if (done !== 1'b1 || busy !== 1'b0 || sum !== vs[j] || cout !== vo[j]) begin
                errors++;
                $display("FAIL b2b_done[%0d]: done=%0b busy=%0b sum=%h cout=%0b, required 1 0 %h %0b",
                         j, done, busy, sum, cout, vs[j], vo[j]);
            end
            $display("b2b: %h+%h -> sum=%h cout=%0b", va[j], vb[j], sum, cout);
            tick();
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: busy=%0b done=%0b, required 0 0", busy, done);
        end
    endtask

    task automatic test_width4_random();
        logic [3:0] ea, eb;
        logic       ec;
        logic [4:0] expv;
        a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom); start4 = 1'b1;
        tick();
        for (int n = 0; n < 200; n++) begin
            ea = a4; eb = b4; ec = cin4;
            expv = 5'(ea) + 5'(eb) + 5'(ec);
            a4 = 4'($urandom); b4 = 4'($urandom); cin4 = 1'($urandom);
            if (n == 199) start4 = 1'b0;
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (busy4 !== 1'b1 || done4 !== 1'b0) begin
                    errors++;
                    $display("FAIL w4_busy[%0d.%0d]: busy=%0b done=%0b, required 1 0", n, i, busy4, done4);
                end
                tick();
            end
            checks++;
            if (done4 !== 1'b1 || {cout4, sum4} !== expv) begin
                errors++;
                $display("FAIL w4_result[%0d]: done=%0b {cout,sum}=%h, required 1 %h", n, done4, {cout4, sum4}, expv);
            end
            $display("w4 op %0d: %h+%h+%0b -> %h", n, ea, eb, ec, {cout4, sum4});
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_basic(8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0);
        test_carry_chain();
        test_start_ignored();
        test_reset_abort();
        test_back_to_back();
        test_width4_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
